// File: rtl/ram_ctrl.sv
// Byte-addressed load/store front-end for a 64-bit word synchronous RAM; sub-dword stores use read-modify-write.
// Latency accept->resp: misaligned 1, dword store 2, load 3, sub-dword store 4; one request outstanding, response held until resp_ready.
module ram_ctrl #(
  parameter int ADDRESS_SIZE  = 11,
  parameter int MEM_WORD_SIZE = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDRESS_SIZE+2:0]   req_addr,
  input  logic [MEM_WORD_SIZE-1:0]  req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [MEM_WORD_SIZE-1:0]  resp_rdata,
  output logic                      resp_error,
  output logic [ADDRESS_SIZE-1:0]   ram_address,
  output logic                      ram_isReading,
  output logic [MEM_WORD_SIZE-1:0]  ram_dataIn,
  input  logic [MEM_WORD_SIZE-1:0]  ram_dataOut
);

  localparam int W = MEM_WORD_SIZE;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;

  logic [2:0]              state_q, state_d;
  logic                    req_ready_q;
  logic                    wr_q;
  logic [1:0]              size_q;
  logic                    sgn_q;
  logic [ADDRESS_SIZE-1:0] idx_q;
  logic [2:0]              off_q;
  logic [W-1:0]            wbuf_q;
  logic [W-1:0]            rdata_q;
  logic                    err_q;

  logic                    accept;
  logic                    misalign_in;
  logic [2:0]              align_mask;
  logic [5:0]              shift;
  logic [W-1:0]            lmask;
  logic [W-1:0]            lane;
  logic                    lane_msb;
  logic [W-1:0]            load_val;
  logic [W-1:0]            merged;

  assign accept = req_valid && req_ready_q;

  always_comb begin
    align_mask = 3'b000;
    case (req_size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign misalign_in = (req_addr[2:0] & align_mask) != 3'b000;

  // Lane extraction and merge both work on the latched size/offset.
  always_comb begin
    lmask = '0;
    case (size_q)
      2'd0:    lmask = {{(W-8){1'b0}},  8'hFF};
      2'd1:    lmask = {{(W-16){1'b0}}, 16'hFFFF};
      2'd2:    lmask = {{(W-32){1'b0}}, 32'hFFFF_FFFF};
      default: lmask = '1;
    endcase
  end

  assign shift = {off_q, 3'b000};
  assign lane  = (ram_dataOut >> shift) & lmask;

  always_comb begin
    lane_msb = 1'b0;
    case (size_q)
      2'd0:    lane_msb = lane[7];
      2'd1:    lane_msb = lane[15];
      2'd2:    lane_msb = lane[31];
      default: lane_msb = lane[W-1];
    endcase
  end

  assign load_val = (sgn_q && lane_msb) ? (lane | ~lmask) : lane;
  assign merged   = (ram_dataOut & ~(lmask << shift)) | ((wbuf_q & lmask) << shift);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misalign_in)                        state_d = ST_RESP;
          else if (req_write && req_size == 2'd3) state_d = ST_WRITE;
          else                                    state_d = ST_ISSUE;
        end
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = wr_q ? ST_WRITE : ST_RESP;
      ST_WRITE:   state_d = ST_RESP;
      ST_RESP:    if (resp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      idx_q       <= '0;
      off_q       <= 3'd0;
      wbuf_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      if (state_q == ST_IDLE && accept) begin
        wr_q    <= req_write;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        idx_q   <= req_addr[ADDRESS_SIZE+2:3];
        off_q   <= req_addr[2:0];
        // Store data parks in the write buffer; dword stores write it as-is.
        wbuf_q  <= req_wdata;
        rdata_q <= '0;
        err_q   <= misalign_in;
      end
      if (state_q == ST_CAPTURE) begin
        if (wr_q) wbuf_q  <= merged;
        else      rdata_q <= load_val;
      end
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_error    = err_q;
  assign ram_address   = idx_q;
  assign ram_isReading = (state_q != ST_WRITE);
  assign ram_dataIn    = wbuf_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: RAM model plus byte-level reference memory predicting every response.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [13:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [10:0] ram_address;
  logic        ram_isReading;
  logic [63:0] ram_dataIn;
  logic [63:0] ram_dataOut = '0;

  int vectors = 0;
  int fails = 0;
  int low_cnt = 0;

  logic [63:0] mem [0:2047];
  logic [7:0]  mb  [0:16383];

  bit          exp_active = 1'b0;
  logic [63:0] exp_rdata = '0;
  logic        exp_error = 1'b0;

  ram_ctrl #(.ADDRESS_SIZE(11), .MEM_WORD_SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_address(ram_address), .ram_isReading(ram_isReading),
    .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!ram_isReading) mem[ram_address] <= ram_dataIn;
    ram_dataOut <= mem[ram_address];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input int addr, input int sz, input bit sg);
    logic [63:0] v;
    int n;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(mb[addr+i]) << (8*i));
    if (sg && mb[addr+n-1][7])
      for (int i = n; i < 8; i++) v = v | (64'hFF << (8*i));
    return v;
  endfunction

  // Single compare process: response contents whenever presented, none when not expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_active && resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_error", 64'(resp_error), 64'(exp_error));
        chk("req_ready_during_resp", 64'(req_ready), 64'd0);
      end else if (!exp_active) begin
        chk("resp_valid_unexpected", 64'(resp_valid), 64'd0);
      end
      if (!ram_isReading) low_cnt++;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
  endtask

  task automatic drive(input bit wr, input logic [1:0] sz, input bit sg,
                       input logic [13:0] addr, input logic [63:0] wd);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [13:0] addr, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er);
    bit mis;
    int exp_lat, lat;
    mis = (int'(addr) % (1 << sz)) != 0;
    exp_lat = mis ? 1 : (wr && sz == 2'd3) ? 2 : !wr ? 3 : 4;
    @(negedge clk);
    wait_ready();
    exp_error = mis;
    exp_rdata = (!wr && !mis) ? model_load(int'(addr), int'(sz), sg) : 64'd0;
    exp_active = 1'b1;
    drive(wr, sz, sg, addr, wd);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    chk("latency", 64'(lat), 64'(exp_lat));
    rd = resp_rdata;
    er = resp_error;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    exp_active = 1'b0;
    if (wr && !mis)
      for (int i = 0; i < (1 << sz); i++) mb[int'(addr)+i] = wd[8*i +: 8];
  endtask

  logic [63:0] rd, snap;
  logic        er;
  int          low0;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    for (int i = 0; i < 16384; i++) mb[i] = '0;

    // Reset values while held low.
    repeat (3) begin
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk("rst_resp_error", 64'(resp_error), 64'd0);
      chk("rst_isReading", 64'(ram_isReading), 64'd1);
      chk("rst_address", 64'(ram_address), 64'd0);
      chk("rst_dataIn", ram_dataIn, 64'd0);
    end
    rst_n = 1'b1;
    #1 chk("req_ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("req_ready_after_release", 64'(req_ready), 64'd1);

    // Dword round trip.
    low0 = low_cnt;
    do_req(1'b1, 2'd3, 1'b0, 14'h040, 64'hDEADBEEF_CAFEF00D, rd, er);
    do_req(1'b0, 2'd3, 1'b0, 14'h040, 64'd0, rd, er);
    chk("dword_rt", rd, 64'hDEADBEEF_CAFEF00D);
    chk("dword_rt_err", 64'(er), 64'd0);
    chk("dword_rt_write_cycles", 64'(low_cnt - low0), 64'd1);

    // Byte read-modify-write and extension.
    do_req(1'b1, 2'd3, 1'b0, 14'h040, 64'd0, rd, er);
    low0 = low_cnt;
    do_req(1'b1, 2'd0, 1'b0, 14'h043, 64'h0000_0000_0000_00AB, rd, er);
    chk("byte_store_write_cycles", 64'(low_cnt - low0), 64'd1);
    do_req(1'b0, 2'd3, 1'b0, 14'h040, 64'd0, rd, er);
    chk("rmw_dword", rd, 64'h00000000_AB000000);
    do_req(1'b0, 2'd0, 1'b1, 14'h043, 64'd0, rd, er);
    chk("byte_signed", rd, 64'hFFFFFFFF_FFFFFFAB);
    do_req(1'b0, 2'd0, 1'b0, 14'h043, 64'd0, rd, er);
    chk("byte_unsigned", rd, 64'h00000000_000000AB);

    // Misaligned half store.
    low0 = low_cnt;
    do_req(1'b1, 2'd1, 1'b0, 14'h041, 64'hFFFF, rd, er);
    chk("misaligned_err", 64'(er), 64'd1);
    chk("misaligned_rdata", rd, 64'd0);
    chk("misaligned_no_write", 64'(low_cnt - low0), 64'd0);
    do_req(1'b0, 2'd3, 1'b0, 14'h040, 64'd0, rd, er);
    chk("after_misaligned", rd, 64'h00000000_AB000000);
    do_req(1'b0, 2'd2, 1'b0, 14'h042, 64'd0, rd, er);
    chk("misaligned_load_err", 64'(er), 64'd1);

    // Half store, signed half and unsigned word loads.
    do_req(1'b1, 2'd1, 1'b0, 14'h046, 64'h1234_BEEF, rd, er);
    do_req(1'b0, 2'd1, 1'b1, 14'h046, 64'd0, rd, er);
    chk("half_signed", rd, 64'hFFFFFFFF_FFFFBEEF);
    do_req(1'b0, 2'd2, 1'b0, 14'h044, 64'd0, rd, er);
    chk("word_unsigned", rd, 64'h00000000_BEEF0000);

    // Backpressure with a competing request held on the bus.
    @(negedge clk);
    wait_ready();
    exp_error = 1'b0;
    exp_rdata = model_load(14'h040, 3, 1'b0);
    exp_active = 1'b1;
    drive(1'b0, 2'd3, 1'b0, 14'h040, 64'd0);
    @(posedge clk);
    #1 drive(1'b1, 2'd3, 1'b0, 14'h040, 64'h5555_5555_5555_5555);
    for (int n = 0; n < 20 && !resp_valid; n++) @(negedge clk);
    snap = resp_rdata;
    chk("bp_rdata", snap, 64'hBEEF0000_AB000000);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_rdata_stable", resp_rdata, snap);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    exp_active = 1'b0;
    do_req(1'b0, 2'd3, 1'b0, 14'h040, 64'd0, rd, er);
    chk("bp_not_accepted", rd, 64'hBEEF0000_AB000000);

    // Reset during the WRITE cycle of a dword store.
    do_req(1'b1, 2'd3, 1'b0, 14'h080, 64'h2222, rd, er);
    @(negedge clk);
    wait_ready();
    drive(1'b1, 2'd3, 1'b0, 14'h080, 64'h1111);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("write_cycle_isReading", 64'(ram_isReading), 64'd0);
    rst_n = 1'b0;
    #1 chk("reset_kills_write", 64'(ram_isReading), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 2'd3, 1'b0, 14'h080, 64'd0, rd, er);
    chk("reset_write_abandoned", rd, 64'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Request/response front-end that sits directly upstream of the word-addressed synchronous RAM. It turns byte-addressed CPU load/store requests (byte, half, word, dword; signed or unsigned loads) into the RAM's `isReading`/`address`/`dataIn` protocol. Sub-dword stores are performed by read-modify-write. It also guarantees the RAM is never written except in the single cycle a store commits.

## Interface

**Parameters**
- `ADDRESS_SIZE`, default 11: RAM word-address width.
- `MEM_WORD_SIZE`, default 64: RAM word width. Only 64 is supported.

**Ports**
- `clk` input 1: clock; all state changes on posedge.
- `rst_n` input 1: reset; one clock, reset asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept a request.
- `req_write` input 1: 1 = store, 0 = load.
- `req_size` input 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_signed` input 1: sign-extend load result; ignored for stores.
- `req_addr` input `ADDRESS_SIZE+3`: byte address.
- `req_wdata` input 64: store data, right-aligned (low bits used).
- `resp_valid` output 1: response present.
- `resp_ready` input 1: consumer accepts the response.
- `resp_rdata` output 64: load result; 0 for stores and for errors.
- `resp_error` output 1: request was misaligned.
- `ram_address` output `ADDRESS_SIZE`: to RAM `address`.
- `ram_isReading` output 1: to RAM `isReading`.
- `ram_dataIn` output 64: to RAM `dataIn`.
- `ram_dataOut` input 64: from RAM `dataOut`; valid one cycle after the address is presented.

## Operation

- **One outstanding request**, no pipelining. A request is accepted on a posedge with `req_valid && req_ready`. All request fields are latched at that edge.
- **Address split:**
  - word index = `req_addr[ADDRESS_SIZE+2:3]`.
  - byte offset `off` = `req_addr[2:0]`.
  - lane = bits `[8*off +: 8<<size]`, little-endian.
- **Misaligned** means `off` is not a multiple of `1<<size`.
  - Transition IDLE→RESP with no RAM access.
  - `resp_error` = 1, `resp_rdata` = 0.
- **States:** IDLE, ISSUE, CAPTURE, WRITE, RESP.
  - **IDLE:** `req_ready` = 1.
    - Accepted load → ISSUE.
    - Accepted dword store → WRITE.
    - Accepted sub-dword store → ISSUE.
    - Accepted misaligned request → RESP.
  - **ISSUE:** `ram_address` = latched index, `ram_isReading` = 1 → CAPTURE.
  - **CAPTURE:** `ram_dataOut` is valid.
    - Load: extract the lane. Zero-extend, or sign-extend from the lane MSB if `req_signed` = 1. Register into `resp_rdata` → RESP.
    - Store: merge the low `8<<size` bits of `req_wdata` into the lane; other bytes are preserved. Register the result into the write buffer → WRITE.
  - **WRITE:** `ram_isReading` = 0, `ram_dataIn` = write buffer (dword store: `req_wdata` unchanged), `ram_address` = index. The RAM commits at the edge ending this state → RESP.
  - **RESP:** `resp_valid` = 1. `resp_rdata`/`resp_error` are held stable until `resp_ready` = 1 at a posedge → IDLE.
- `ram_isReading` = 1 in every state except WRITE, including during reset.
- `req_ready` = 0 in every state except IDLE. `req_valid` outside IDLE is ignored and not queued.

## Timing

- **Reset values** (asynchronous on `rst_n` low, held while low):
  - state = IDLE
  - `req_ready` = 0 (registered; rises at the first posedge after `rst_n` rises)
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_error` = 0
  - `ram_isReading` = 1, `ram_address` = 0, `ram_dataIn` = 0
- **Latency**, accept edge to the first cycle `resp_valid` = 1:
  - misaligned request: 1 cycle
  - dword store: 2 cycles
  - load: 3 cycles
  - sub-dword store: 4 cycles
- **Throughput:** the next request can be accepted at the first edge on which `req_ready` is sampled 1 again, one cycle after the response handshake edge.
- **Reset mid-operation:** the request is abandoned and no response is produced. If `rst_n` falls before the edge that ends WRITE, `ram_isReading` is already 1, so the store is not committed.
- **Back-to-back:** a store followed by a load to the same word returns the stored value; the RAM write precedes the read issue.

## Test plan

- **Reset.** Hold `rst_n` low for 3 cycles, then release → during reset all outputs are at their reset values; `req_ready` = 1 from the first posedge after release.
- **Dword round trip.** Dword store of 0xDEADBEEF_CAFEF00D to 0x040, then dword load from 0x040 → `resp_rdata` = 0xDEADBEEF_CAFEF00D, `resp_error` = 0. Latencies are 2 and 3 cycles. `ram_isReading` = 0 for exactly 1 cycle in total.
- **Byte RMW and extension.** Dword store of 0 to 0x040, byte store of 0xAB to 0x043, then:
  - dword load from 0x040 → 0x00000000_AB000000
  - signed byte load from 0x043 → 0xFFFFFFFF_FFFFFFAB
  - unsigned byte load from 0x043 → 0x00000000_000000AB
- **Misaligned.** Half store to 0x041 → `resp_error` = 1, `resp_rdata` = 0 after 1 cycle; `ram_isReading` stays 1 throughout; a following dword load from 0x040 still returns 0x00000000_AB000000.
- **Backpressure.** Load with `resp_ready` = 0 for 5 cycles while `req_valid` = 1 with other requests → `resp_valid` held 1; `resp_rdata` stable; `req_ready` = 0; the other requests are not accepted.
- **Reset during WRITE.** Assert `rst_n` low during the WRITE cycle of a dword store of 0x1111 to 0x080 whose prior contents are 0x2222. After release, a dword load from 0x080 → 0x2222.
